// File: rtl/mpc_challenge_stream.sv
// mpc_challenge_stream: walks the packed r/eps challenge words of the MPC
// expander and serializes them into one (r_j, eps_j) element pair per beat
// on a valid/ready stream, tagged with (e, d, j) indices and last flags.
module mpc_challenge_stream #(
    parameter string PARAMETER_SET = "L1",
    parameter int    TAU           = 17,
    parameter int    D_SPLIT       = (PARAMETER_SET == "L1") ? 1 : 2,
    parameter int    T             = (PARAMETER_SET == "L5") ? 4 : 3,
    parameter int    W             = TAU * D_SPLIT,
    localparam int   AW            = (W > 1) ? $clog2(W) : 1,
    localparam int   EW            = (TAU > 1) ? $clog2(TAU) : 1,
    localparam int   DW            = (D_SPLIT > 1) ? $clog2(D_SPLIT) : 1,
    localparam int   JW            = (T > 1) ? $clog2(T) : 1
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic            i_start,
    output logic            o_busy,
    output logic            o_done,
    output logic            o_r_rd,
    output logic [AW-1:0]   o_r_addr,
    input  logic [T*32-1:0] i_r,
    output logic            o_eps_rd,
    output logic [AW-1:0]   o_eps_addr,
    input  logic [T*32-1:0] i_eps,
    output logic            o_valid,
    input  logic            i_ready,
    output logic [31:0]     o_r_elem,
    output logic [31:0]     o_eps_elem,
    output logic [EW-1:0]   o_e_idx,
    output logic [DW-1:0]   o_d_idx,
    output logic [JW-1:0]   o_j_idx,
    output logic            o_last_j,
    output logic            o_last
);

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        WAIT,
        EMIT,
        DONE
    } state_t;

    state_t               state;
    logic [AW-1:0]        addr;
    logic [T-1:0][31:0]   r_word;
    logic [T-1:0][31:0]   eps_word;
    logic [JW-1:0]        j_inc;
    logic                 j_inc_last;
    logic                 word_last;

    // Helpers for the next element and for end-of-word / end-of-run decisions
    assign j_inc      = o_j_idx + JW'(1);
    assign j_inc_last = (j_inc == JW'(T - 1));
    assign word_last  = (addr == AW'(W - 1));

    // Sequencer: owns every registered output so all beat fields change together
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            state      <= IDLE;
            addr       <= '0;
            r_word     <= '0;
            eps_word   <= '0;
            o_busy     <= 1'b0;
            o_done     <= 1'b0;
            o_r_rd     <= 1'b0;
            o_r_addr   <= '0;
            o_eps_rd   <= 1'b0;
            o_eps_addr <= '0;
            o_valid    <= 1'b0;
            o_r_elem   <= '0;
            o_eps_elem <= '0;
            o_e_idx    <= '0;
            o_d_idx    <= '0;
            o_j_idx    <= '0;
            o_last_j   <= 1'b0;
            o_last     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    o_done <= 1'b0;
                    if (i_start) begin
                        state      <= FETCH;
                        addr       <= '0;
                        o_e_idx    <= '0;
                        o_d_idx    <= '0;
                        o_j_idx    <= '0;
                        o_busy     <= 1'b1;
                        o_r_rd     <= 1'b1;
                        o_r_addr   <= '0;
                        o_eps_rd   <= 1'b1;
                        o_eps_addr <= '0;
                    end
                end
                FETCH: begin
                    // Strobes last exactly one cycle; address returns to 0 with them
                    o_r_rd     <= 1'b0;
                    o_r_addr   <= '0;
                    o_eps_rd   <= 1'b0;
                    o_eps_addr <= '0;
                    state      <= WAIT;
                end
                WAIT: begin
                    // Read data is only valid now; first beat comes straight from it
                    r_word     <= i_r;
                    eps_word   <= i_eps;
                    o_r_elem   <= i_r[31:0];
                    o_eps_elem <= i_eps[31:0];
                    o_j_idx    <= '0;
                    o_last_j   <= (T == 1);
                    o_last     <= (T == 1) && word_last;
                    o_valid    <= 1'b1;
                    state      <= EMIT;
                end
                EMIT: begin
                    if (i_ready) begin
                        if (o_j_idx != JW'(T - 1)) begin
                            o_j_idx    <= j_inc;
                            o_r_elem   <= r_word[j_inc];
                            o_eps_elem <= eps_word[j_inc];
                            o_last_j   <= j_inc_last;
                            o_last     <= j_inc_last && word_last;
                        end else begin
                            o_valid  <= 1'b0;
                            o_last_j <= 1'b0;
                            o_last   <= 1'b0;
                            if (!word_last) begin
                                addr       <= addr + AW'(1);
                                o_r_rd     <= 1'b1;
                                o_r_addr   <= addr + AW'(1);
                                o_eps_rd   <= 1'b1;
                                o_eps_addr <= addr + AW'(1);
                                if (o_d_idx == DW'(D_SPLIT - 1)) begin
                                    o_d_idx <= '0;
                                    o_e_idx <= o_e_idx + EW'(1);
                                end else begin
                                    o_d_idx <= o_d_idx + DW'(1);
                                end
                                state <= FETCH;
                            end else begin
                                o_done <= 1'b1;
                                state  <= DONE;
                            end
                        end
                    end
                end
                DONE: begin
                    o_done <= 1'b0;
                    o_busy <= 1'b0;
                    state  <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mpc_challenge_stream.sv
// Bench for mpc_challenge_stream: one DUT per parameter set (L1/L3/L5), a
// pattern memory per DUT, and a cycle-level behavioural model of the beat
// stream derived from word/element arithmetic.
module tb_mpc_challenge_stream;

    localparam int NC = 3;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          ready = 1'b1;
    logic [NC-1:0] start = '0;

    logic [NC-1:0] valid_b, done_b, busy_b, rrd_b, erd_b, lastj_b, last_b, nz_b;
    logic [5:0]    raddr_b [NC];
    logic [5:0]    eaddr_b [NC];
    logic [31:0]   rel_b   [NC];
    logic [31:0]   eel_b   [NC];
    logic [4:0]    e_b     [NC];
    logic [0:0]    d_b     [NC];
    logic [1:0]    j_b     [NC];

    int tick = 0, run_t0 = 0, go_seq = 0, seen_seq = 0, end_seq = 0;
    int cur = 0, mode = 0;
    bit lit_on = 1'b0;
    int vectors = 0, miscompares = 0;

    bit active = 1'b0;
    int n, fetch_cyc, last_hs, reads, cyc, nb, ww, tt, ds, a, j;
    bit ev, erd, edn;

    always #5 clk = ~clk;

    function automatic int ds_of(input int c);
        return (c == 0) ? 1 : 2;
    endfunction
    function automatic int t_of(input int c);
        return (c == 2) ? 4 : 3;
    endfunction
    function automatic int lit_beats(input int c);
        return (c == 0) ? 51 : (c == 1) ? 102 : 136;
    endfunction
    function automatic int lit_done(input int c);
        return (c == 0) ? 86 : (c == 1) ? 171 : 205;
    endfunction
    function automatic longint lit_last_r(input int c);
        return (c == 0) ? 64'h1000_0102 : (c == 1) ? 64'h1000_0212 : 64'h1000_0213;
    endfunction

    genvar g;
    for (g = 0; g < NC; g++) begin : cfg
        localparam string PS = (g == 0) ? "L1" : ((g == 1) ? "L3" : "L5");
        localparam int    DS = (g == 0) ? 1 : 2;
        localparam int    TT = (g == 2) ? 4 : 3;
        localparam int    AW = $clog2(17 * DS);

        logic            r_rd, e_rd, valid, done, busy, lastj, last;
        logic [AW-1:0]   r_addr, e_addr;
        logic [TT*32-1:0] r_dat, e_dat;
        logic [31:0]     rel, eel;
        logic [4:0]      ei;
        logic [0:0]      di;
        logic [1:0]      ji;

        mpc_challenge_stream #(.PARAMETER_SET(PS)) dut (
            .i_clk     (clk),
            .i_rst     (rst_n),
            .i_start   (start[g]),
            .o_busy    (busy),
            .o_done    (done),
            .o_r_rd    (r_rd),
            .o_r_addr  (r_addr),
            .i_r       (r_dat),
            .o_eps_rd  (e_rd),
            .o_eps_addr(e_addr),
            .i_eps     (e_dat),
            .o_valid   (valid),
            .i_ready   (ready),
            .o_r_elem  (rel),
            .o_eps_elem(eel),
            .o_e_idx   (ei),
            .o_d_idx   (di),
            .o_j_idx   (ji),
            .o_last_j  (lastj),
            .o_last    (last)
        );

        // Pattern memory, 1-cycle latency; junk on the bus when not read
        always @(posedge clk) begin
            for (int k = 0; k < TT; k++) begin
                r_dat[k*32 +: 32] <= r_rd ? 32'h1000_0000 + 32'(16 * int'(r_addr) + k) : $urandom;
                e_dat[k*32 +: 32] <= e_rd ? 32'h2000_0000 + 32'(16 * int'(e_addr) + k) : $urandom;
            end
        end

        assign valid_b[g] = valid;
        assign done_b[g]  = done;
        assign busy_b[g]  = busy;
        assign rrd_b[g]   = r_rd;
        assign erd_b[g]   = e_rd;
        assign lastj_b[g] = lastj;
        assign last_b[g]  = last;
        assign raddr_b[g] = 6'(r_addr);
        assign eaddr_b[g] = 6'(e_addr);
        assign rel_b[g]   = rel;
        assign eel_b[g]   = eel;
        assign e_b[g]     = ei;
        assign d_b[g]     = di;
        assign j_b[g]     = ji;
        assign nz_b[g]    = |{busy, done, r_rd, r_addr, e_rd, e_addr, valid, rel, eel,
                              ei, di, ji, lastj, last};
    end

    task automatic chk(input string nm, input longint act, input longint exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, want 0x%0h (cfg %0d, tick %0d)", nm, act, exp, cur, tick);
        end
    endtask

    // Consumer ready: always 1, or a coin flip per cycle
    always @(posedge clk) begin
        #1;
        ready = (mode == 1) ? 1'($urandom_range(0, 1)) : 1'b1;
    end

    // Single compare process: model of the beat stream, checked every cycle
    always @(negedge clk) begin
        tick = tick + 1;
        if (!rst_n) begin
            for (int k = 0; k < NC; k++) chk("reset_zero", longint'(nz_b[k]), 0);
            if (active) begin
                active = 1'b0;
                end_seq++;
            end
        end else begin
            if (go_seq != seen_seq && tick == run_t0) begin
                seen_seq = go_seq;
                active = 1'b1;
                n = 0; fetch_cyc = 1; last_hs = -10; reads = 0;
                tt = t_of(cur); ds = ds_of(cur); ww = 17 * ds; nb = ww * tt;
            end
            if (active) begin
                cyc = tick - run_t0;
                a = n / tt;
                j = n % tt;
                ev = (n < nb) && (cyc >= fetch_cyc + 2);
                chk("valid", longint'(valid_b[cur]), longint'(ev));
                if (ev && valid_b[cur]) begin
                    chk("r_elem", longint'(rel_b[cur]), 64'h1000_0000 + 16 * a + j);
                    chk("eps_elem", longint'(eel_b[cur]), 64'h2000_0000 + 16 * a + j);
                    chk("e_idx", longint'(e_b[cur]), a / ds);
                    chk("d_idx", longint'(d_b[cur]), a % ds);
                    chk("j_idx", longint'(j_b[cur]), j);
                    chk("last_j", longint'(lastj_b[cur]), longint'(j == tt - 1));
                    chk("last", longint'(last_b[cur]), longint'(n == nb - 1));
                    if (n == nb - 1) chk("final_r_literal", longint'(rel_b[cur]), lit_last_r(cur));
                    if (cur == 1 && n == 15) begin
                        chk("l3_addr5_e", longint'(e_b[cur]), 2);
                        chk("l3_addr5_d", longint'(d_b[cur]), 1);
                    end
                end
                erd = (n < nb) && (cyc == fetch_cyc);
                chk("r_rd", longint'(rrd_b[cur]), longint'(erd));
                chk("eps_rd", longint'(erd_b[cur]), longint'(erd));
                chk("r_addr", longint'(raddr_b[cur]), erd ? a : 0);
                chk("eps_addr", longint'(eaddr_b[cur]), erd ? a : 0);
                if (rrd_b[cur]) reads++;
                chk("busy", longint'(busy_b[cur]), longint'(cyc >= 1));
                edn = (n == nb) && (cyc == last_hs + 1);
                chk("done", longint'(done_b[cur]), longint'(edn));
                if (valid_b[cur] && ready) begin
                    last_hs = cyc;
                    if (j == tt - 1) fetch_cyc = cyc + 1;
                    n++;
                end
                if (done_b[cur]) begin
                    chk("beat_count", n, lit_beats(cur));
                    chk("read_count", reads, ww);
                    if (lit_on) chk("done_cycle", cyc, lit_done(cur));
                    active = 1'b0;
                    end_seq++;
                end else if (cyc > 3000) begin
                    miscompares++;
                    $display("FAIL run_timeout: no o_done after %0d cycles (cfg %0d)", cyc, cur);
                    active = 1'b0;
                    end_seq++;
                end
            end else begin
                for (int k = 0; k < NC; k++)
                    chk("idle_quiet", longint'({busy_b[k], valid_b[k], done_b[k], rrd_b[k], erd_b[k]}), 0);
            end
        end
    end

    int prev_end;

    task automatic begin_run(input int c, input int m, input bit l);
        cur = c;
        mode = m;
        lit_on = l;
        prev_end = end_seq;
        @(posedge clk);
        #1;
        run_t0 = tick + 1;
        go_seq++;
        start[c] = 1'b1;
        @(posedge clk);
        #1;
        start[c] = 1'b0;
    endtask

    task automatic wait_end();
        for (int k = 0; k < 5000 && end_seq == prev_end; k++) @(posedge clk);
        if (end_seq == prev_end) begin
            $display("FAIL bench_stall: run never closed (cfg %0d)", cur);
            $fatal(1, "bench stalled");
        end
    endtask

    initial begin
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (2) @(posedge clk);

        // L1, always ready
        begin_run(0, 0, 1'b1); wait_end();
        // L1, random backpressure
        begin_run(0, 1, 1'b0); wait_end();
        // L1 with a stray start pulse in cycle 40
        begin_run(0, 0, 1'b1);
        repeat (39) @(posedge clk);
        #1 start[0] = 1'b1;
        @(posedge clk);
        #1 start[0] = 1'b0;
        wait_end();
        // Fresh run right after: must restart at address 0
        begin_run(0, 0, 1'b1); wait_end();
        // Reset during EMIT of word 7, then a full run
        begin_run(0, 0, 1'b0);
        repeat (37) @(posedge clk);
        #3 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        wait_end();
        repeat (4) @(posedge clk);
        begin_run(0, 0, 1'b1); wait_end();
        // L3 and L5
        begin_run(1, 0, 1'b1); wait_end();
        begin_run(2, 0, 1'b1); wait_end();
        begin_run(2, 1, 1'b0); wait_end();
        begin_run(1, 1, 1'b0); wait_end();
        repeat (3) @(posedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
